pong_disp_scan: RTL and testbench
=================================

// Module: pong_disp_scan
// PURPOSE
//  Display scanner for the pong game. Sits directly downstream of the game-logic block.
//  Takes bar and ball positions and produces the time-multiplexed 10-bit LED matrix word LEDOUT.
//  Holds one object pixel per slot for a fixed dwell time, in a fixed round-robin frame.
//  Samples positions once at each frame start, so an object never tears mid-frame.
// PARAMETERS
//  BAR_LEN      3      bar length in pixels (1..8)
//  BAR1_ROW     4'd12  matrix row of bar 1
//  BAR2_ROW     4'd3   matrix row of bar 2
//  DWELL        2000   CLK cycles per slot (>=2)
//  BALL_SLOTS   3      slots given to the ball per frame (sets ball brightness)
//  BLANK_SLOTS  119    blank slots closing each frame (>=1); default frame = 128 slots
// PORTS
//  CLK          in   1   clock
//  RSTn         in   1   reset, asynchronous, active-low
//  disp_en      in   1   1 = scan; 0 = blank output, return to IDLE
//  bar1_x       in   3   left column of bar 1
//  bar2_x       in   3   left column of bar 2
//  ball_x       in   3   ball column
//  ball_y       in   4   ball row
//  LEDOUT       out  10  {obj[1:0],1'b0,row[3:0],col[2:0]}; obj 10=bar, 01=ball, 00=blank
//  frame_start  out  1   one-cycle pulse, asserted the cycle after a frame begins
// BEHAVIOUR
//  Reset values:
//  - LEDOUT=0, frame_start=0, state=IDLE, slot idx=0, dwell cnt=0, snapshot regs=0.
//  States: IDLE -> BAR1 (BAR_LEN slots) -> BAR2 (BAR_LEN) -> BALL (BALL_SLOTS) -> BLANK (BLANK_SLOTS) -> BAR1 ...
//  IDLE:
//  - While disp_en=0: stay in IDLE, LEDOUT=0.
//  - First edge with disp_en=1 starts a frame.
//  Frame start (IDLE exit, or end of the last BLANK slot):
//  - On the same edge, snapshot <= live inputs.
//  - On the same edge, LEDOUT <= slot-0 word computed from the live inputs.
//  - frame_start=1 for the following cycle only.
//  Slot timing:
//  - cnt counts 0..DWELL-1.
//  - At cnt==DWELL-1: cnt<=0, advance slot/state, and register LEDOUT for the new slot on that edge.
//  - Each word is therefore held exactly DWELL cycles.
//  Slot words (all from the snapshot, except slot 0 as above):
//  - BAR1 slot i: col = bar1_x+i, computed 4-bit. col>7 gives a blank word (0), no wrap. Otherwise {10,0,BAR1_ROW,col}.
//  - BAR2 slot i: same rule with bar2_x and BAR2_ROW.
//  - BALL slots: {01,0,ball_y,ball_x}; every BALL slot carries the identical word.
//  - BLANK slots: 0.
//  Frame length = (2*BAR_LEN+BALL_SLOTS+BLANK_SLOTS)*DWELL cycles.
//  Input changes mid-frame are ignored until the next frame start.
//  disp_en falling mid-frame:
//  - On the next edge: state=IDLE, LEDOUT=0, cnt=0, idx=0, frame_start=0.
//  - Snapshot is retained but not used.
//  RSTn low at any time forces all reset values immediately (asynchronous).
//  After RSTn is released, the first frame starts on the first edge with disp_en=1.
//  Width rules:
//  - cnt is $clog2(DWELL) bits.
//  - idx is wide enough for max(BAR_LEN,BALL_SLOTS,BLANK_SLOTS).
//  - Bar column add is done at 4 bits before the >7 check.
// STRUCTURE
//  Package pong_pkg: OBJ_BAR=2'b10, OBJ_BALL=2'b01, OBJ_NONE=2'b00.
//  Package pong_pkg: scan state enum {IDLE,BAR1,BAR2,BALL,BLANK}.
//  Package pong_pkg: function pack_led(obj,row,col) returning the 10-bit word.
//  Package pong_pkg: BAR1_ROW/BAR2_ROW defaults, shared with the game-logic block.
//  Sub-module disp_slot_timer (DWELL): cnt register and slot_done pulse; the FSM consumes slot_done.
// TESTING  (DWELL=4, BAR_LEN=3, BALL_SLOTS=3, BLANK_SLOTS=2 unless noted)
//  1 Reset, disp_en=1, bar1_x=2, bar2_x=4, ball=(5,7):
//    - expect LEDOUT sequence 0x262,0x263,0x264,0x21C,0x21D,0x21E,0x13D x3,0 x2, each held 4 cycles.
//    - expect frame_start every 44 cycles.
//  2 bar2_x=6: BAR2 slots give 0x21E, 0x21F, then 0 (col 8 blanked, no wrap to col 0).
//  3 Change ball_x to 1 in the middle of the BAR2 slots: current frame still shows 0x13D; next frame shows 0x139.
//  4 disp_en 1->0 during a BALL slot:
//    - LEDOUT=0 on the next edge and stays 0.
//    - Re-enable: first edge gives the BAR1 word and frame_start pulses.
//  5 Assert RSTn low asynchronously mid-slot: LEDOUT=0 and frame_start=0 before the next edge; restart as in test 1.
//  6 Default parameters: 128*2000 = 256000-cycle frame period; ball word held 6000 cycles per frame.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: object codes, bar rows, scan states and LED word packing.
package pong_pkg;

   localparam logic [1:0] OBJ_BAR  = 2'b10;
   localparam logic [1:0] OBJ_BALL = 2'b01;
   localparam logic [1:0] OBJ_NONE = 2'b00;

   // Bar rows are shared with the game-logic block so collisions match what is drawn.
   localparam logic [3:0] BAR1_ROW_DEF = 4'd12;
   localparam logic [3:0] BAR2_ROW_DEF = 4'd3;

   typedef enum logic [2:0] {IDLE, BAR1, BAR2, BALL, BLANK} scan_state_t;

   function automatic logic [9:0] pack_led(input logic [1:0] obj, input logic [3:0] row,
                                           input logic [2:0] col);
      return {obj, 1'b0, row, col};
   endfunction

   // A bar pixel that runs off the right edge is blanked rather than wrapped.
   function automatic logic [9:0] bar_word(input logic [2:0] x, input logic [3:0] off,
                                           input logic [3:0] row);
      logic [3:0] col;
      col = {1'b0, x} + off;
      if (col > 4'd7) return '0;
      return pack_led(OBJ_BAR, row, col[2:0]);
   endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Dwell counter for one display slot; slot_done marks the last cycle of a slot.
module disp_slot_timer #(
   parameter int DWELL = 2000
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic run,
   output logic slot_done
);

   localparam int CNT_W = $clog2(DWELL);

   logic [CNT_W-1:0] cnt;

   assign slot_done = run && (cnt == CNT_W'(DWELL - 1));

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)                  cnt <= '0;
      else if (!run || slot_done) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pong_disp_scan.sv
// Pong display scanner: round-robin bar/ball/blank slots, positions snapshotted per frame.
module pong_disp_scan
   import pong_pkg::*;
#(
   parameter int         BAR_LEN     = 3,
   parameter logic [3:0] BAR1_ROW    = BAR1_ROW_DEF,
   parameter logic [3:0] BAR2_ROW    = BAR2_ROW_DEF,
   parameter int         DWELL       = 2000,
   parameter int         BALL_SLOTS  = 3,
   parameter int         BLANK_SLOTS = 119
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       disp_en,
   input  logic [2:0] bar1_x,
   input  logic [2:0] bar2_x,
   input  logic [2:0] ball_x,
   input  logic [3:0] ball_y,
   output logic [9:0] LEDOUT,
   output logic       frame_start
);

   localparam int IDX_MAX = (BAR_LEN > BALL_SLOTS) ?
                            ((BAR_LEN > BLANK_SLOTS) ? BAR_LEN : BLANK_SLOTS) :
                            ((BALL_SLOTS > BLANK_SLOTS) ? BALL_SLOTS : BLANK_SLOTS);
   localparam int IDX_W   = $clog2(IDX_MAX + 1);

   scan_state_t      state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [3:0]       idx_off;
   logic [2:0]       snap_bar1;
   logic [2:0]       snap_bar2;
   logic [2:0]       snap_ball_x;
   logic [3:0]       snap_ball_y;
   logic             run;
   logic             slot_done;
   logic             start;

   assign run     = disp_en && (state != IDLE);
   assign idx_nxt = idx + IDX_W'(1);
   assign idx_off = 4'(idx_nxt);
   assign start   = (state == IDLE) ||
                    (slot_done && state == BLANK && idx == IDX_W'(BLANK_SLOTS - 1));

   disp_slot_timer #(.DWELL(DWELL)) u_timer (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .run       (run),
      .slot_done (slot_done)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state       <= IDLE;
         idx         <= '0;
         LEDOUT      <= '0;
         frame_start <= 1'b0;
         snap_bar1   <= '0;
         snap_bar2   <= '0;
         snap_ball_x <= '0;
         snap_ball_y <= '0;
      end else if (!disp_en) begin
         state       <= IDLE;
         idx         <= '0;
         LEDOUT      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (start) begin
            // Slot 0 is built from the live inputs since the snapshot updates on this same edge.
            state       <= BAR1;
            idx         <= '0;
            LEDOUT      <= bar_word(bar1_x, 4'd0, BAR1_ROW);
            frame_start <= 1'b1;
            snap_bar1   <= bar1_x;
            snap_bar2   <= bar2_x;
            snap_ball_x <= ball_x;
            snap_ball_y <= ball_y;
         end else if (slot_done) begin
            case (state)
               BAR1: begin
                  if (idx == IDX_W'(BAR_LEN - 1)) begin
                     state  <= BAR2;
                     idx    <= '0;
                     LEDOUT <= bar_word(snap_bar2, 4'd0, BAR2_ROW);
                  end else begin
                     idx    <= idx_nxt;
                     LEDOUT <= bar_word(snap_bar1, idx_off, BAR1_ROW);
                  end
               end
               BAR2: begin
                  if (idx == IDX_W'(BAR_LEN - 1)) begin
                     state  <= BALL;
                     idx    <= '0;
                     LEDOUT <= pack_led(OBJ_BALL, snap_ball_y, snap_ball_x);
                  end else begin
                     idx    <= idx_nxt;
                     LEDOUT <= bar_word(snap_bar2, idx_off, BAR2_ROW);
                  end
               end
               BALL: begin
                  if (idx == IDX_W'(BALL_SLOTS - 1)) begin
                     state  <= BLANK;
                     idx    <= '0;
                     LEDOUT <= pack_led(OBJ_NONE, 4'd0, 3'd0);
                  end else begin
                     idx    <= idx_nxt;
                     LEDOUT <= pack_led(OBJ_BALL, snap_ball_y, snap_ball_x);
                  end
               end
               BLANK: begin
                  idx    <= idx_nxt;
                  LEDOUT <= '0;
               end
               default: begin
                  state  <= IDLE;
                  idx    <= '0;
                  LEDOUT <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_disp_scan.sv
// Scoreboard bench for pong_disp_scan with small dwell/frame parameters.
module tb_pong_disp_scan;

   localparam int DWELL   = 4;
   localparam int BAR_LEN = 3;
   localparam int BALL_N  = 3;
   localparam int BLANK_N = 2;
   localparam int NSLOT   = 2 * BAR_LEN + BALL_N + BLANK_N;
   localparam int FRAME   = NSLOT * DWELL;

   typedef struct {
      logic [9:0] led;
      logic       fs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] bar1_x, bar2_x, ball_x;
   logic [3:0] ball_y;
   logic [9:0] ledout;
   logic       frame_start;

   exp_t       expq[$];
   logic [9:0] words[NSLOT];
   int         pos = -1;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         last_fs = 0;
   int         fs_gap = 0;

   always #5 clk = ~clk;

   pong_disp_scan #(
      .BAR_LEN(BAR_LEN), .BAR1_ROW(4'd12), .BAR2_ROW(4'd3),
      .DWELL(DWELL), .BALL_SLOTS(BALL_N), .BLANK_SLOTS(BLANK_N)
   ) dut (
      .CLK(clk), .RSTn(rst_n), .disp_en(en),
      .bar1_x(bar1_x), .bar2_x(bar2_x), .ball_x(ball_x), .ball_y(ball_y),
      .LEDOUT(ledout), .frame_start(frame_start)
   );

   // Reference: a frame is a list of slot words fixed at frame start; each shown DWELL cycles.
   always @(posedge clk) begin
      exp_t e;
      if (!rst_n || !en) begin
         pos = -1;
         e   = '{10'h0, 1'b0};
      end else if (pos < 0 || pos == FRAME - 1) begin
         for (int i = 0; i < BAR_LEN; i++) begin
            int c1, c2;
            c1 = int'(bar1_x) + i;
            c2 = int'(bar2_x) + i;
            words[i]           = (c1 > 7) ? 10'h0 : 10'('h200 + 12 * 8 + c1);
            words[BAR_LEN + i] = (c2 > 7) ? 10'h0 : 10'('h200 + 3 * 8 + c2);
         end
         for (int i = 0; i < BALL_N; i++)
            words[2 * BAR_LEN + i] = 10'('h100 + int'(ball_y) * 8 + int'(ball_x));
         for (int i = 0; i < BLANK_N; i++)
            words[2 * BAR_LEN + BALL_N + i] = 10'h0;
         pos = 0;
         e   = '{words[0], 1'b1};
      end else begin
         pos++;
         e = '{words[pos / DWELL], 1'b0};
      end
      expq.push_back(e);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pos(input int lo, input int hi, input string name);
      int k;
      k = 0;
      while (!(pos >= lo && pos <= hi) && k < 3 * FRAME) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (k >= 3 * FRAME) begin
         miscompares++;
         $display("FAIL %s: frame position %0d never reached %0d..%0d", name, pos, lo, hi);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0;
      bar1_x = 3'd0; bar2_x = 3'd0; ball_x = 3'd0; ball_y = 4'd0;
      fork
         forever begin : monitor
            exp_t e2;
            @(negedge clk);
            cyc++;
            vectors++;
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL sb_empty: cyc=%0d got led=%h, no expectation queued", cyc, ledout);
            end else begin
               e2 = expq.pop_front();
               if (ledout !== e2.led || frame_start !== e2.fs) begin
                  miscompares++;
                  $display("FAIL ledout: cyc=%0d got led=%h fs=%b, expected led=%h fs=%b",
                           cyc, ledout, frame_start, e2.led, e2.fs);
               end
            end
            if (frame_start === 1'b1) begin
               fs_gap  = cyc - last_fs;
               last_fs = cyc;
            end
         end
         begin : stimulus
            #1;
            vectors++;
            if (ledout !== 10'h0 || frame_start !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_state: got led=%h fs=%b, expected 000/0", ledout, frame_start);
            end
            step(3);
            bar1_x = 3'd2; bar2_x = 3'd4; ball_x = 3'd5; ball_y = 4'd7;
            rst_n = 1'b1; en = 1'b1;
            step(2 * FRAME + 5);
            vectors++;
            if (fs_gap != FRAME) begin
               miscompares++;
               $display("FAIL frame_period: got %0d cycles, expected %0d", fs_gap, FRAME);
            end
            // Bar 2 runs off the right edge: last pixel must blank, not wrap.
            bar2_x = 3'd6;
            step(2 * FRAME);
            // Ball moves during the BAR2 slots; only the next frame may show it.
            wait_pos(4 * DWELL, 5 * DWELL, "bar2_slot");
            ball_x = 3'd1;
            step(2 * FRAME);
            // Drop enable during a BALL slot, then re-enable.
            wait_pos(6 * DWELL + 1, 8 * DWELL, "ball_slot");
            en = 1'b0;
            step(10);
            en = 1'b1;
            step(FRAME + 10);
            // Asynchronous reset mid-slot.
            #2 rst_n = 1'b0;
            #1;
            vectors++;
            if (ledout !== 10'h0 || frame_start !== 1'b0) begin
               miscompares++;
               $display("FAIL async_reset: got led=%h fs=%b, expected 000/0", ledout, frame_start);
            end
            step(2);
            rst_n = 1'b1;
            step(FRAME + 5);
            for (int n = 0; n < 1500; n++) begin
               if ($urandom_range(7) == 0) begin
                  bar1_x = 3'($urandom_range(7));
                  bar2_x = 3'($urandom_range(7));
                  ball_x = 3'($urandom_range(7));
                  ball_y = 4'($urandom_range(15));
               end
               if (en && $urandom_range(150) == 0)      en = 1'b0;
               else if (!en && $urandom_range(5) == 0)  en = 1'b1;
               if ($urandom_range(400) == 0) begin
                  #2 rst_n = 1'b0;
                  step(1);
                  rst_n = 1'b1;
               end else begin
                  step(1);
               end
            end
            step(3);
         end
      join_any
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
